rv64g_l1_refill_arbiter: RTL and testbench
==========================================

# rv64g_l1_refill_arbiter

Shares the single L1 refill port of the main cache controller among `NUM_REQ` refill requesters: requester 0 is the scalar L1 miss path and requester 1 is the vector LSU miss handler. It latches one-cycle refill pulses and arbitrates round-robin. It issues one refill at a time and returns a done pulse to every requester served by that line. Same-line requests pending at grant time are merged into a single refill.

## Interface
Parameters:
- `NUM_REQ`, 2, number of requesters (2..4).
- `WDOG_CYCLES`, 255, watchdog limit in cycles (only with the watchdog macro).

Ports:
- `clk_i`  in  1  clock; one clock domain.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `req_valid_i`  in  NUM_REQ  one-cycle refill request pulse per requester.
- `req_addr_i`  in  NUM_REQ*64  request address; requester k uses bits [64k+63:64k]. Sampled only with its pulse.
- `req_done_o`  out  NUM_REQ  one-cycle pulse when that requester's line has been filled.
- `refill_req_o`  out  1  one-cycle refill request to the cache controller.
- `refill_addr_o`  out  64  line-aligned refill address. Valid in ISSUE and WAIT, otherwise 0.
- `refill_done_i`  in  1  refill-complete pulse from the cache controller.
- `busy_o`  out  1  high while in ISSUE or WAIT.
- `grant_o`  out  NUM_REQ  serve mask of the refill currently in flight.
- `ovf_o`  out  1  sticky flag: a request arrived while that requester was already pending.
- `timeout_o`  out  1  sticky flag: the watchdog expired.

## Operation
- Per-requester storage:
  - `pend_q[k]` pending bit.
  - `addr_q[k]` line address, bits [63:6]; bits [5:0] are forced to 0 on capture.
- Capture: `req_valid_i[k]` with `pend_q[k]=0` sets `pend_q[k]` and loads `addr_q[k]` on the next edge.
  - If `pend_q[k]=1` and the pending entry is not being cleared this cycle, the request is dropped and `ovf_o` is set.
- Round-robin pointer `rr_q` (reset 0): the winner is the first pending requester at or after `rr_q`, searching upward modulo `NUM_REQ`.
- FSM states:
  - IDLE: if any `pend_q` bit is set, register the winner and the serve mask, then go to ISSUE. The serve mask is the winner plus every pending requester whose `addr_q` equals the winner's `addr_q`.
  - ISSUE: `refill_req_o=1`, `refill_addr_o={addr_q[winner],6'b0}`, then go to WAIT.
  - WAIT: hold `refill_addr_o`. On `refill_done_i`:
    - `req_done_o = grant_o` in the same cycle (combinational).
    - Clear `pend_q` for every bit of `grant_o`.
    - Set `rr_q = winner+1` (mod `NUM_REQ`).
    - Go to IDLE.
- `refill_done_i` outside WAIT is ignored.
- Requests captured during WAIT are never merged into the in-flight refill, even for the same line. They wait for a later grant.
- A request from a served requester in the same cycle its done fires is accepted as a new pending entry; clear and set are evaluated in that order.
- Asynchronous reset mid-operation drops all pending entries, returns to IDLE and sets `rr_q=0`.

## Timing
- All outputs reset to 0: `req_done_o`, `refill_req_o`, `refill_addr_o`, `busy_o`, `grant_o`, `ovf_o`, `timeout_o`.
- Minimum latency, from a request pulse at cycle N with the block idle:
  - pending at N+1 (IDLE grants);
  - ISSUE at N+2 with `refill_req_o` high;
  - WAIT from N+3.
- `req_done_o` pulses in the cycle `refill_done_i` is sampled in WAIT. The next grant can occur one cycle after that done cycle, so back-to-back refills are separated by one IDLE cycle.

## Configuration
- `RV64G_L1_REFILL_WDOG_EN` defined:
  - An 8-bit-or-wider counter runs in WAIT and clears on entry to WAIT.
  - When it reaches `WDOG_CYCLES` without `refill_done_i`, `timeout_o` is set and the FSM returns to ISSUE. This reissues the same address and keeps the same serve mask.
- Not defined: no counter; WAIT holds indefinitely; `timeout_o` is tied to 0.

## Structure
- Shared package (`rv64g_l1_pkg`) holds:
  - FSM state enum (IDLE/ISSUE/WAIT);
  - `LINE_OFF_W=6`;
  - `LINE_ADDR_W=58`.
- One sub-module, `rv64g_rr_pick`: a combinational round-robin priority picker taking the request vector and pointer and returning a one-hot winner plus its index. All state stays in the arbiter.

## Test plan
- Single request: requester 1 pulses at cycle 0 with addr 0x1000_0047.
  - Required: `refill_req_o` at cycle 2 with addr 0x1000_0040.
  - Required: done at cycle 5 gives `req_done_o=2'b10` at cycle 5.
- Simultaneous requests with different lines: requesters 0 and 1 pulse together with `rr_q=0`.
  - Required: requester 0 is served first, then requester 1.
  - Required: a second identical pair is served with requester 1 first.
- Merge: both requesters pulse together for 0x2000 and 0x2010.
  - Required: exactly one `refill_req_o`, `grant_o=2'b11`, `req_done_o=2'b11` on done.
- Overflow: requester 0 pulses twice before its grant completes.
  - Required: `ovf_o=1` the cycle after the second pulse; a single refill is issued.
- Reset mid-WAIT: assert `rst_ni=0` while busy.
  - Required: all outputs are 0 immediately.
  - Required: a later `refill_done_i` yields no `req_done_o`.
- Watchdog (macro on, `WDOG_CYCLES=10`): no done after ISSUE.
  - Required: `timeout_o=1` and a second `refill_req_o` with the same address after 10 WAIT cycles.

Source files
------------

// File: rtl/rv64g_l1_pkg.sv
// Shared types and line-geometry constants for the L1 refill arbiter.
package rv64g_l1_pkg;

  localparam int unsigned ADDR_W      = 64;
  localparam int unsigned LINE_OFF_W  = 6;
  localparam int unsigned LINE_ADDR_W = 58;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } refill_state_e;

  // Full byte address of the first byte of a line.
  function automatic logic [ADDR_W-1:0] line_base(input logic [LINE_ADDR_W-1:0] line);
    return {line, {LINE_OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/rv64g_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, modulo N.
module rv64g_rr_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_oh,
  output logic [IDX_W-1:0] gnt_idx
);

  logic        found;
  int unsigned pos;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = (32'(ptr) + i) % N;
      if (!found && req[pos[IDX_W-1:0]]) begin
        found                   = 1'b1;
        gnt_oh[pos[IDX_W-1:0]] = 1'b1;
        gnt_idx                 = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/rv64g_l1_refill_arbiter.sv
// Shares the L1 refill port among NUM_REQ requesters with round-robin and same-line merging.
// Optional watchdog reissue enabled by defining RV64G_L1_REFILL_WDOG_EN.
module rv64g_l1_refill_arbiter import rv64g_l1_pkg::*; #(
  parameter int unsigned NUM_REQ = 2
`ifdef RV64G_L1_REFILL_WDOG_EN
  , parameter int unsigned WDOG_CYCLES = 255
`endif
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]        req_done_o,
  output logic                      refill_req_o,
  output logic [ADDR_W-1:0]         refill_addr_o,
  input  logic                      refill_done_i,
  output logic                      busy_o,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      ovf_o,
  output logic                      timeout_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef RV64G_L1_REFILL_WDOG_EN
  localparam int unsigned WDOG_W = (WDOG_CYCLES > 255) ? $clog2(WDOG_CYCLES + 1) : 8;
`endif

  refill_state_e          state_q;
  logic [NUM_REQ-1:0]     pend_q;
  logic [LINE_ADDR_W-1:0] addr_q [NUM_REQ];
  logic [NUM_REQ-1:0]     grant_q;
  logic [IDX_W-1:0]       rr_q;
  logic [IDX_W-1:0]       win_q;
  logic [NUM_REQ-1:0]     pick_oh;
  logic [IDX_W-1:0]       pick_idx;
  logic [NUM_REQ-1:0]     serve_mask;
  logic [NUM_REQ-1:0]     clr_mask;
  logic                   done_fire;
  logic                   unused_addr_lo;
`ifdef RV64G_L1_REFILL_WDOG_EN
  logic [WDOG_W-1:0]      wdog_q;
`endif

  rv64g_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (pend_q),
    .ptr     (rr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx)
  );

  // Completion is only honoured in WAIT; it retires every requester merged into the grant.
  assign done_fire  = (state_q == ST_WAIT) && refill_done_i;
  assign clr_mask   = done_fire ? grant_q : '0;
  assign req_done_o = clr_mask;
  assign grant_o    = grant_q;

  // Winner plus every other pending entry targeting the same line.
  always_comb begin
    serve_mask = pick_oh;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (pend_q[k] && (addr_q[k] == addr_q[pick_idx])) serve_mask[k] = 1'b1;
    end
  end

  // Line offset bits are discarded on capture.
  always_comb begin
    unused_addr_lo = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      unused_addr_lo = unused_addr_lo ^ (^req_addr_i[ADDR_W*k +: LINE_OFF_W]);
    end
  end

  // Pending capture: a slot freed by this cycle's done may be refilled in the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
      ovf_o  <= 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) addr_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (req_valid_i[k] && (!pend_q[k] || clr_mask[k])) begin
          pend_q[k] <= 1'b1;
          addr_q[k] <= req_addr_i[ADDR_W*k + LINE_OFF_W +: LINE_ADDR_W];
        end else begin
          if (clr_mask[k])                 pend_q[k] <= 1'b0;
          if (req_valid_i[k] && pend_q[k]) ovf_o     <= 1'b1;
        end
      end
    end
  end

  // Refill sequencing with registered port outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      rr_q          <= '0;
      win_q         <= '0;
      grant_q       <= '0;
      refill_req_o  <= 1'b0;
      refill_addr_o <= '0;
      busy_o        <= 1'b0;
`ifdef RV64G_L1_REFILL_WDOG_EN
      wdog_q        <= '0;
      timeout_o     <= 1'b0;
`endif
    end else begin
      refill_req_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|pend_q) begin
            state_q       <= ST_ISSUE;
            win_q         <= pick_idx;
            grant_q       <= serve_mask;
            refill_req_o  <= 1'b1;
            refill_addr_o <= line_base(addr_q[pick_idx]);
            busy_o        <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
`ifdef RV64G_L1_REFILL_WDOG_EN
          wdog_q  <= '0;
`endif
        end
        ST_WAIT: begin
          if (refill_done_i) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            refill_addr_o <= '0;
            busy_o        <= 1'b0;
            rr_q          <= (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
          end
`ifdef RV64G_L1_REFILL_WDOG_EN
          else if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
            // Reissue the same line with the same serve mask.
            state_q      <= ST_ISSUE;
            refill_req_o <= 1'b1;
            timeout_o    <= 1'b1;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifndef RV64G_L1_REFILL_WDOG_EN
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_rv64g_l1_refill_arbiter.sv
// Self-checking bench for rv64g_l1_refill_arbiter against a cycle-level behavioural model.
module tb_rv64g_l1_refill_arbiter;

  localparam int unsigned N = 2;
`ifdef RV64G_L1_REFILL_WDOG_EN
  localparam int unsigned WD = 10;
`endif

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*64-1:0] req_addr;
  logic [N-1:0]   req_done_o;
  logic           refill_req_o;
  logic [63:0]    refill_addr_o;
  logic           refill_done;
  logic           busy_o;
  logic [N-1:0]   grant_o;
  logic           ovf_o;
  logic           timeout_o;

  rv64g_l1_refill_arbiter #(
    .NUM_REQ(N)
`ifdef RV64G_L1_REFILL_WDOG_EN
    , .WDOG_CYCLES(WD)
`endif
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_valid_i   (req_valid),
    .req_addr_i    (req_addr),
    .req_done_o    (req_done_o),
    .refill_req_o  (refill_req_o),
    .refill_addr_o (refill_addr_o),
    .refill_done_i (refill_done),
    .busy_o        (busy_o),
    .grant_o       (grant_o),
    .ovf_o         (ovf_o),
    .timeout_o     (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [71:0] dut_vec;
  assign dut_vec = {req_done_o, refill_req_o, refill_addr_o, busy_o, grant_o, ovf_o, timeout_o};

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state: pending table, rr pointer and the refill in flight.
  logic [N-1:0]  m_pend;
  logic [57:0]   m_line [N];
  int            m_rr;
  int            m_win;
  logic [N-1:0]  m_mask;
  logic [63:0]   m_addr_out;
  bit            m_inflight;
  bit            m_issue;
  bit            m_ovf;
  bit            m_to;
  int            m_wcnt;
  logic [N-1:0]  cur_v;
  logic [N*64-1:0] cur_a;
  logic          cur_d;
  logic [N-1:0]  exp_done;
  logic [71:0]   exp_vec;

  function automatic void model_reset();
    m_pend = '0; m_rr = 0; m_win = 0; m_mask = '0; m_addr_out = '0;
    m_inflight = 0; m_issue = 0; m_ovf = 0; m_to = 0; m_wcnt = 0;
    for (int k = 0; k < N; k++) m_line[k] = '0;
  endfunction

  function automatic void model_outputs();
    exp_done = (m_inflight && !m_issue && cur_d) ? m_mask : '0;
    exp_vec  = {exp_done, 1'(m_inflight && m_issue), (m_inflight ? m_addr_out : 64'd0),
                1'(m_inflight), (m_inflight ? m_mask : N'(0)), 1'(m_ovf), 1'(m_to)};
  endfunction

  function automatic void model_advance();
    int w;
    logic [N-1:0] clr;
    clr = exp_done;
    if (!m_inflight) begin
      w = -1;
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_rr + i) % N;
        if (w < 0 && m_pend[k]) w = k;
      end
      if (w >= 0) begin
        m_inflight = 1; m_issue = 1; m_win = w;
        m_addr_out = {m_line[w], 6'b0};
        m_mask = '0;
        for (int k = 0; k < N; k++) if (m_pend[k] && m_line[k] == m_line[w]) m_mask[k] = 1'b1;
      end
    end else if (m_issue) begin
      m_issue = 0; m_wcnt = 0;
    end else if (cur_d) begin
      m_inflight = 0; m_rr = (m_win + 1) % N;
    end
`ifdef RV64G_L1_REFILL_WDOG_EN
    else if (m_wcnt == WD - 1) begin
      m_issue = 1; m_to = 1;
    end else begin
      m_wcnt++;
    end
`endif
    for (int k = 0; k < N; k++) begin
      if (cur_v[k]) begin
        if (!m_pend[k] || clr[k]) begin
          m_pend[k] = 1'b1;
          m_line[k] = cur_a[64*k+6 +: 58];
        end else begin
          m_ovf = 1;
        end
      end else if (clr[k]) begin
        m_pend[k] = 1'b0;
      end
    end
  endfunction

  task automatic cycle_begin(input logic [N-1:0] v, input logic [N*64-1:0] a, input logic d);
    req_valid = v; req_addr = a; refill_done = d;
    cur_v = v; cur_a = a; cur_d = d;
    @(negedge clk);
    model_outputs();
  endtask

  task automatic cycle_end();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0; req_addr = '0; refill_done = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_valid = '0; req_addr = '0; refill_done = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (dut_vec !== 72'd0) begin
      n_err++; $display("FAIL reset_state dut=%h exp=0", dut_vec);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      cycle_begin('0, '0, 1'b0);
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL reset_idle c%0d dut=%h exp=%h", c, dut_vec, exp_vec);
      end
      cycle_end();
    end
  endtask

  task automatic test_single();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      cycle_begin(c == 0 ? 2'b10 : 2'b00, {64'h1000_0047, 64'h0}, c == 5);
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL single c%0d dut=%h exp=%h", c, dut_vec, exp_vec);
      end
      if (c == 2) begin
        n_checks++;
        if (refill_req_o !== 1'b1 || refill_addr_o !== 64'h1000_0040) begin
          n_err++; $display("FAIL single_issue req=%b addr=%h exp req=1 addr=1000_0040", refill_req_o, refill_addr_o);
        end
      end
      if (c == 5) begin
        n_checks++;
        if (req_done_o !== 2'b10) begin
          n_err++; $display("FAIL single_done got=%b exp=10", req_done_o);
        end
      end
      cycle_end();
    end
  endtask

  // Second pair lands in the first done cycle: requester 0 re-arms, requester 1 is still pending.
  task automatic test_round_robin();
    do_reset();
    for (int c = 0; c < 15; c++) begin
      cycle_begin((c == 0 || c == 4) ? 2'b11 : 2'b00, {64'h3000_0000, 64'h4000_0000},
                  (c == 4 || c == 8 || c == 12));
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL rr c%0d dut=%h exp=%h", c, dut_vec, exp_vec);
      end
      if (c == 2 || c == 6 || c == 10) begin
        n_checks++;
        if (grant_o !== ((c == 6) ? 2'b10 : 2'b01)) begin
          n_err++; $display("FAIL rr_order c%0d grant=%b exp=%b", c, grant_o, (c == 6) ? 2'b10 : 2'b01);
        end
      end
      cycle_end();
    end
  endtask

  task automatic test_merge();
    int reqs;
    reqs = 0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      cycle_begin(c == 0 ? 2'b11 : 2'b00, {64'h2010, 64'h2000}, c == 4);
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL merge c%0d dut=%h exp=%h", c, dut_vec, exp_vec);
      end
      if (refill_req_o === 1'b1) reqs++;
      if (c == 2) begin
        n_checks++;
        if (grant_o !== 2'b11) begin
          n_err++; $display("FAIL merge_grant got=%b exp=11", grant_o);
        end
      end
      if (c == 4) begin
        n_checks++;
        if (req_done_o !== 2'b11) begin
          n_err++; $display("FAIL merge_done got=%b exp=11", req_done_o);
        end
      end
      cycle_end();
    end
    n_checks++;
    if (reqs != 1) begin
      n_err++; $display("FAIL merge_count got=%0d exp=1", reqs);
    end
  endtask

  task automatic test_overflow();
    int reqs;
    reqs = 0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      cycle_begin((c == 0 || c == 1) ? 2'b01 : 2'b00, {64'h0, 64'h5000}, c == 4);
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL ovf c%0d dut=%h exp=%h", c, dut_vec, exp_vec);
      end
      if (refill_req_o === 1'b1) reqs++;
      if (c == 2) begin
        n_checks++;
        if (ovf_o !== 1'b1) begin
          n_err++; $display("FAIL ovf_flag got=%b exp=1", ovf_o);
        end
      end
      cycle_end();
    end
    n_checks++;
    if (reqs != 1) begin
      n_err++; $display("FAIL ovf_count got=%0d exp=1", reqs);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      cycle_begin(c == 0 ? 2'b11 : 2'b00, {64'h6100, 64'h6000}, (c == 4 || c == 8));
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL b2b c%0d dut=%h exp=%h", c, dut_vec, exp_vec);
      end
      if (c == 5 || c == 6) begin
        n_checks++;
        if (refill_req_o !== (c == 6)) begin
          n_err++; $display("FAIL b2b_gap c%0d req=%b exp=%b", c, refill_req_o, c == 6);
        end
      end
      cycle_end();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      cycle_begin(c == 0 ? 2'b01 : 2'b00, {64'h0, 64'h9000_0080}, 1'b0);
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL rstmid c%0d dut=%h exp=%h", c, dut_vec, exp_vec);
      end
      if (c < 3) cycle_end();
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut_vec !== 72'd0) begin
      n_err++; $display("FAIL rstmid_async dut=%h exp=0", dut_vec);
    end
    refill_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      cycle_begin('0, '0, 1'b1);
      n_checks++;
      if (dut_vec !== exp_vec || req_done_o !== 2'b00) begin
        n_err++; $display("FAIL rstmid_done c%0d dut=%h exp=%h", c, dut_vec, exp_vec);
      end
      cycle_end();
    end
  endtask

`ifdef RV64G_L1_REFILL_WDOG_EN
  task automatic test_watchdog();
    do_reset();
    for (int c = 0; c < 19; c++) begin
      cycle_begin(c == 0 ? 2'b01 : 2'b00, {64'h0, 64'h7000}, c == 16);
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL wdog c%0d dut=%h exp=%h", c, dut_vec, exp_vec);
      end
      if (c == 12 || c == 13) begin
        n_checks++;
        if (refill_req_o !== (c == 13) || timeout_o !== (c == 13) || refill_addr_o !== 64'h7000) begin
          n_err++; $display("FAIL wdog_reissue c%0d req=%b to=%b addr=%h", c, refill_req_o, timeout_o, refill_addr_o);
        end
      end
      cycle_end();
    end
  endtask
`endif

  task automatic test_random();
    logic [N-1:0]    v;
    logic [N*64-1:0] a;
    logic [63:0]     t;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) begin
        v[k] = ($urandom_range(0, 5) == 0);
        t = 64'h8000_0000 + 64'($urandom_range(0, 3)) * 64 + 64'($urandom_range(0, 63));
        a[64*k +: 64] = t;
      end
      cycle_begin(v, a, $urandom_range(0, 3) == 0);
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL random c%0d dut=%h exp=%h", c, dut_vec, exp_vec);
      end
      cycle_end();
    end
  endtask

  initial begin
    rst_n = 1'b1;
    req_valid = '0; req_addr = '0; refill_done = 1'b0;
    cur_v = '0; cur_a = '0; cur_d = 1'b0; exp_done = '0; exp_vec = '0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_merge();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
`ifdef RV64G_L1_REFILL_WDOG_EN
    test_watchdog();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
